// File: rtl/mem_stream_pkg.sv
// Shared definitions for the MEM read-side streamer.
//   stream_state_e     sequencer states: idle, issuing reads, draining the buffer
//   STREAM_FIFO_DEPTH  output buffer depth; also bounds the words in flight plus buffered
//   FIFO_COUNT_WIDTH   width of the occupancy count reported by stream_fifo2
//   MEM_READ_LATENCY   read-to-valid latency of the attached MEM. The in-flight tracker
//                      is a single bit, so it only supports a latency of 1.
package mem_stream_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } stream_state_e;

  localparam int unsigned STREAM_FIFO_DEPTH = 2;
  localparam int unsigned FIFO_COUNT_WIDTH  = $clog2(STREAM_FIFO_DEPTH + 1);
  localparam int unsigned MEM_READ_LATENCY  = 1;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry registered FIFO that buffers MEM return data for the output stream.
//   clk, rst    clock and synchronous active-low reset
//   push        write data_in this cycle; dropped if full and not popping
//   pop         remove the head entry; ignored when empty
//   data_in     word to write
//   count       current occupancy (0..2)
//   head_data   oldest entry; holds its value until popped
//   head_valid  at least one entry present
module stream_fifo2
  import mem_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic [DATA_WIDTH-1:0]       data_in,
  output logic [FIFO_COUNT_WIDTH-1:0] count,
  output logic [DATA_WIDTH-1:0]       head_data,
  output logic                        head_valid
);

  logic [DATA_WIDTH-1:0]       slot0_q, slot0_d;
  logic [DATA_WIDTH-1:0]       slot1_q, slot1_d;
  logic [FIFO_COUNT_WIDTH-1:0] count_q, count_d;
  logic                        do_push;
  logic                        do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q < FIFO_COUNT_WIDTH'(STREAM_FIFO_DEPTH)) || do_pop);

  // slot0 is always the head; a pop shifts slot1 down.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10: begin
        if (count_q == '0) begin
          slot0_d = data_in;
        end else begin
          slot1_d = data_in;
        end
        count_d = count_q + FIFO_COUNT_WIDTH'(1);
      end
      2'b01: begin
        slot0_d = slot1_q;
        count_d = count_q - FIFO_COUNT_WIDTH'(1);
      end
      2'b11: begin
        if (count_q == FIFO_COUNT_WIDTH'(1)) begin
          slot0_d = data_in;
        end else begin
          slot0_d = slot1_q;
          slot1_d = data_in;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= '0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign head_data  = slot0_q;
  assign head_valid = (count_q != '0);

endmodule

// File: rtl/mem_read_streamer.sv
// Read-side sequencer in front of the single-port-read MEM BRAM. A start command walks a
// contiguous, wrapping address window issuing one read per word; the registered return is
// buffered and presented as a valid/ready stream. MEM cannot stall, so a read is issued
// only when a buffer slot is guaranteed for its data.
//   clk, rst        clock and synchronous active-low reset
//   start           command strobe, sampled only while idle
//   base_addr       first address, sampled with start
//   num_words       transfer length (0 legal), sampled with start
//   busy            transfer in progress
//   done            one-cycle completion pulse
//   mem_addr_read   to MEM.addr_read
//   mem_read        to MEM.read
//   mem_data_read   from MEM.data_read
//   mem_valid       from MEM.valid_out
//   data_out        stream data
//   valid_out       stream valid
//   ready_in        stream ready from downstream
module mem_read_streamer
  import mem_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned LOG_MAX_ADDRESS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [LOG_MAX_ADDRESS-1:0] base_addr,
  input  logic [LOG_MAX_ADDRESS:0]   num_words,
  output logic                       busy,
  output logic                       done,
  output logic [LOG_MAX_ADDRESS-1:0] mem_addr_read,
  output logic                       mem_read,
  input  logic [DATA_WIDTH-1:0]      mem_data_read,
  input  logic                       mem_valid,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       valid_out,
  input  logic                       ready_in
);

  stream_state_e                state_q, state_d;
  logic [LOG_MAX_ADDRESS-1:0]   addr_q, addr_d;
  logic [LOG_MAX_ADDRESS:0]     remaining_q, remaining_d;
  logic                         inflight_q, inflight_d;
  logic                         zero_done_q, zero_done_d;

  logic [FIFO_COUNT_WIDTH-1:0]  fifo_count;
  logic [DATA_WIDTH-1:0]        fifo_head;
  logic                         fifo_valid;
  logic                         fifo_push;
  logic                         pop;
  logic                         issue;
  logic                         drain_finish;
  logic [2:0]                   occupancy;
  logic [2:0]                   occupancy_limit;

  // Outputs are gated by rst so they read as reset values for the whole reset window,
  // including the first cycle before the registers have been cleared.
  assign pop = rst && fifo_valid && ready_in;

  // Buffered words plus the one in flight must leave room for the new word, counting a
  // slot freed by this cycle's pop.
  assign occupancy       = 3'(fifo_count) + 3'(inflight_q);
  assign occupancy_limit = 3'(STREAM_FIFO_DEPTH) + 3'(pop);

  assign issue = rst && (state_q == StRun) && (remaining_q != '0) &&
                 (occupancy < occupancy_limit);

  // Returns outside a transfer (e.g. a read issued just before reset) are discarded.
  assign fifo_push = rst && mem_valid && (state_q != StIdle);

  assign drain_finish = (state_q == StDrain) && !inflight_q && (fifo_count == '0) && !pop;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    zero_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (num_words == '0) begin
            zero_done_d = 1'b1;
          end else begin
            state_d     = StRun;
            addr_d      = base_addr;
            remaining_d = num_words;
          end
        end
      end
      StRun: begin
        if (issue) begin
          addr_d      = addr_q + LOG_MAX_ADDRESS'(1);
          remaining_d = remaining_q - (LOG_MAX_ADDRESS + 1)'(1);
          if (remaining_q == (LOG_MAX_ADDRESS + 1)'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (drain_finish) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A new read and the previous return can coincide; the new read keeps the bit set.
  always_comb begin
    inflight_d = inflight_q;
    if (issue) begin
      inflight_d = 1'b1;
    end else if (fifo_push) begin
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
      zero_done_q <= zero_done_d;
    end
  end

  stream_fifo2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .pop       (pop),
    .data_in   (mem_data_read),
    .count     (fifo_count),
    .head_data (fifo_head),
    .head_valid(fifo_valid)
  );

  assign busy          = rst && ((state_q == StRun) || ((state_q == StDrain) && !drain_finish));
  assign done          = rst && (zero_done_q || drain_finish);
  assign mem_read      = issue;
  assign mem_addr_read = rst ? addr_q : '0;
  assign valid_out     = rst && fifo_valid;
  assign data_out      = rst ? fifo_head : '0;

endmodule

// File: tb/tb_mem_read_streamer.sv
// Bench for mem_read_streamer: a behavioural MEM (mem[i] = i+1, one-cycle registered read),
// a transfer-level reference model checked every cycle, directed scenarios with literal
// expectations and randomized transfers with random downstream backpressure.
module tb_mem_read_streamer;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_words = '0;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_addr_read;
  logic          mem_read;
  logic [DW-1:0] mem_data_read;
  logic          mem_valid;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          ready_in = 1'b1;

  mem_read_streamer #(
    .DATA_WIDTH     (DW),
    .LOG_MAX_ADDRESS(AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .num_words    (num_words),
    .busy         (busy),
    .done         (done),
    .mem_addr_read(mem_addr_read),
    .mem_read     (mem_read),
    .mem_data_read(mem_data_read),
    .mem_valid    (mem_valid),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .ready_in     (ready_in)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
    logic [AW-1:0] s;
    s = a + 16'd1;
    return s[7:0];
  endfunction

  // Behavioural MEM; inject forces a stray return to exercise the drop rule.
  logic       mem_valid_q = 1'b0;
  logic [7:0] mem_data_q  = '0;
  logic       inject      = 1'b0;
  always @(posedge clk) begin
    mem_valid_q <= mem_read;
    mem_data_q  <= mem_byte(mem_addr_read);
  end
  assign mem_valid     = mem_valid_q | inject;
  assign mem_data_read = mem_data_q;

  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Downstream ready: 0 always high, 1 random, 2 toggling, 3 low until ready_release.
  int unsigned ready_mode    = 0;
  int unsigned ready_release = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: ready_in = 1'b1;
      1: ready_in = 1'($urandom_range(0, 1));
      2: ready_in = ~ready_in;
      default: ready_in = (cyc >= ready_release);
    endcase
  end

  // Reference model state: unpopped words as (issue cycle, data).
  bit            act_m = 1'b0;
  int unsigned   acc_cyc = 0;
  int unsigned   n_m = 0;
  int unsigned   reads_left = 0;
  logic [AW-1:0] exp_addr = '0;
  int unsigned   iss_cyc_q[$];
  logic [7:0]    iss_dat_q[$];

  // Observed DUT activity for the current transfer, pinned by literal checks.
  int unsigned   rd_cyc_log[$];
  logic [AW-1:0] rd_addr_log[$];
  logic [7:0]    out_log[$];
  int unsigned   out_cyc_log[$];
  int unsigned   done_cyc = 0;
  int unsigned   done_total = 0;
  bit            busy_seen = 1'b0;

  bit exp_valid, pop_now, exp_read, exp_done, exp_busy, act_before;
  int occ;

  always @(negedge clk) begin
    if (!rst) begin
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_mem_read", 64'(mem_read), 64'd0);
      check("rst_mem_addr_read", 64'(mem_addr_read), 64'd0);
      check("rst_valid_out", 64'(valid_out), 64'd0);
      check("rst_data_out", 64'(data_out), 64'd0);
      act_m = 1'b0;
      reads_left = 0;
      iss_cyc_q.delete();
      iss_dat_q.delete();
    end else begin
      exp_valid = (iss_cyc_q.size() > 0) && (cyc >= iss_cyc_q[0] + 2);
      pop_now   = exp_valid && ready_in;
      exp_done  = act_m && (cyc > acc_cyc) && (reads_left == 0) && (iss_cyc_q.size() == 0);
      exp_busy  = act_m && (cyc > acc_cyc) && !exp_done && (n_m != 0);
      occ = iss_cyc_q.size();
      if (pop_now) occ--;
      exp_read = act_m && (cyc > acc_cyc) && (reads_left > 0) && (occ < 2);

      check("valid_out", 64'(valid_out), 64'(exp_valid));
      if (exp_valid) check("data_out", 64'(data_out), 64'(iss_dat_q[0]));
      check("mem_read", 64'(mem_read), 64'(exp_read));
      if (exp_read) check("mem_addr_read", 64'(mem_addr_read), 64'(exp_addr));
      check("done", 64'(done), 64'(exp_done));
      check("busy", 64'(busy), 64'(exp_busy));
      check("fifo_count_le_2", 64'(dut.u_fifo.count <= 2), 64'd1);

      if (mem_read) begin
        rd_cyc_log.push_back(cyc);
        rd_addr_log.push_back(mem_addr_read);
      end
      if (valid_out && ready_in) begin
        out_log.push_back(data_out);
        out_cyc_log.push_back(cyc);
      end
      if (done) begin
        done_cyc = cyc;
        done_total++;
      end
      if (busy) busy_seen = 1'b1;

      act_before = act_m;
      if (exp_read) begin
        iss_cyc_q.push_back(cyc);
        iss_dat_q.push_back(mem_byte(exp_addr));
        exp_addr = exp_addr + 16'd1;
        reads_left--;
      end
      if (pop_now) begin
        void'(iss_cyc_q.pop_front());
        void'(iss_dat_q.pop_front());
      end
      if (exp_done) act_m = 1'b0;
      if (start && !act_before) begin
        act_m      = 1'b1;
        acc_cyc    = cyc;
        n_m        = 32'(num_words);
        reads_left = 32'(num_words);
        exp_addr   = base_addr;
        rd_cyc_log.delete();
        rd_addr_log.delete();
        out_log.delete();
        out_cyc_log.delete();
        done_cyc  = 0;
        busy_seen = 1'b0;
      end
    end
  end

  task automatic do_start(input logic [AW-1:0] b, input int unsigned n, output int unsigned t);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = b;
    num_words = (AW + 1)'(n);
    t         = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned bound, input string name);
    int unsigned k;
    k = 0;
    while (act_m && k < bound) begin
      @(posedge clk);
      k++;
    end
    if (act_m) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: still active after %0d cycles, required done", name, bound);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  int unsigned   t;
  int unsigned   cnt;
  int unsigned   done_before;
  logic [AW-1:0] wrap_addr[4];
  logic [7:0]    wrap_data[4];

  initial begin
    wrap_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    wrap_data = '{8'hFF, 8'h00, 8'h01, 8'h02};

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Full-throughput transfer.
    ready_mode = 0;
    do_start(16'h0010, 4, t);
    wait_idle(100, "s1");
    check("s1_done_latency", 64'(done_cyc - t), 64'd7);
    check("s1_read_count", 64'(rd_cyc_log.size()), 64'd4);
    check("s1_word_count", 64'(out_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < out_log.size(); i++) begin
      check("s1_word", 64'(out_log[i]), 64'(8'h11 + i));
      check("s1_word_cycle", 64'(out_cyc_log[i] - t), 64'(3 + i));
    end

    // Downstream stalled for T..T+10.
    ready_mode    = 3;
    ready_release = 32'hFFFF_FFFF;
    do_start(16'h0010, 4, t);
    ready_release = t + 11;
    wait_idle(200, "s2");
    ready_mode = 0;
    cnt = 0;
    foreach (rd_cyc_log[i]) if (rd_cyc_log[i] < t + 10) cnt++;
    check("s2_reads_while_stalled", 64'(cnt), 64'd2);
    check("s2_word_count", 64'(out_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < out_log.size(); i++) begin
      check("s2_word", 64'(out_log[i]), 64'(8'h11 + i));
    end
    if (out_cyc_log.size() > 0) check("s2_first_pop_cycle", 64'(out_cyc_log[0] - t), 64'd11);

    // Toggling ready.
    ready_mode = 2;
    do_start(16'h0000, 8, t);
    wait_idle(200, "s3");
    ready_mode = 0;
    check("s3_word_count", 64'(out_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < out_log.size(); i++) begin
      check("s3_word", 64'(out_log[i]), 64'(i + 1));
    end

    // Address wrap.
    do_start(16'hFFFE, 4, t);
    wait_idle(100, "s4");
    check("s4_read_count", 64'(rd_addr_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < rd_addr_log.size(); i++) begin
      check("s4_addr", 64'(rd_addr_log[i]), 64'(wrap_addr[i]));
    end
    for (int i = 0; i < 4 && i < out_log.size(); i++) begin
      check("s4_word", 64'(out_log[i]), 64'(wrap_data[i]));
    end

    // Zero-length transfer.
    do_start(16'h0030, 0, t);
    wait_idle(20, "s5");
    check("s5_done_latency", 64'(done_cyc - t), 64'd1);
    check("s5_read_count", 64'(rd_cyc_log.size()), 64'd0);
    check("s5_busy_seen", 64'(busy_seen), 64'd0);

    // Start while busy is ignored.
    do_start(16'h0020, 3, t);
    start     = 1'b1;
    base_addr = 16'h0040;
    num_words = 17'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle(100, "s6");
    check("s6_word_count", 64'(out_log.size()), 64'd3);
    if (out_log.size() == 3) begin
      check("s6_first_word", 64'(out_log[0]), 64'h21);
      check("s6_last_word", 64'(out_log[2]), 64'h23);
    end

    // Reset mid-transfer, stray return while idle, then a fresh transfer.
    do_start(16'h0000, 8, t);
    while (cyc < t + 3) begin
      @(posedge clk);
      #1;
    end
    done_before = done_total;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    inject = 1'b1;
    @(posedge clk);
    #1;
    inject = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("s7_no_done_after_reset", 64'(done_total - done_before), 64'd0);
    do_start(16'h0050, 5, t);
    wait_idle(100, "s7");
    check("s7_fresh_word_count", 64'(out_log.size()), 64'd5);
    check("s7_fresh_done_latency", 64'(done_cyc - t), 64'd8);
    if (out_log.size() > 0) check("s7_fresh_first_word", 64'(out_log[0]), 64'h51);

    // Randomized transfers.
    for (int r = 0; r < 40; r++) begin
      int unsigned n;
      logic [AW-1:0] b;
      ready_mode = $urandom_range(0, 2);
      n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 24);
      b = (r % 5 == 0) ? (16'hFFF0 + 16'($urandom_range(0, 15))) : 16'($urandom);
      do_start(b, n, t);
      wait_idle(2000, "rand");
      check("rand_word_count", 64'(out_log.size()), 64'(n));
      if (ready_mode == 0 && n > 0) check("rand_throughput", 64'(done_cyc - t), 64'(3 + n));
      if (r % 7 == 3) begin
        inject = 1'b1;
        @(posedge clk);
        #1;
        inject = 1'b0;
        repeat (2) @(posedge clk);
        #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
